// File: rtl/system_0_ledg_fader.sv
// LED fader placed behind the LEDG PIO. Each channel ramps a 4-bit brightness
// toward its on/off target and drives a 15-step PWM, controlled over Avalon-MM.
module system_0_ledg_fader #(
  parameter int CHANNELS   = 9,
  parameter int PRESCALE_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] in_port,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [CHANNELS-1:0] led_out
);

  // Avalon-MM slave: a write is accepted on any clk edge with chipselect=1 and
  // write_n=0 (no waitrequest); readdata is a pure function of address.
  logic                  ctrl_enable;
  logic                  ctrl_bypass;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] tcnt;
  logic [3:0]            pcnt;
  logic [3:0]            level [CHANNELS];

  logic                  wr_en;
  logic                  wr_ctrl;
  logic                  wr_prescale;
  logic                  tick;
  logic [CHANNELS-1:0]   status;
  logic [CHANNELS-1:0]   pwm;

  assign wr_en       = chipselect & ~write_n;
  assign wr_ctrl     = wr_en & (address == 2'd0);
  assign wr_prescale = wr_en & (address == 2'd1);

  // A prescale write restarts the tick period, so it also suppresses the tick.
  assign tick = (tcnt == prescale) & ~wr_prescale;

  always_comb begin
    status = '0;
    pwm    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      status[i] = (level[i] == {4{in_port[i]}});
      pwm[i]    = (level[i] > pcnt);
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata = {30'd0, ctrl_bypass, ctrl_enable};
      2'd1:    readdata = 32'(prescale);
      2'd2:    readdata = 32'(status);
      default: readdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_enable <= 1'b1;
      ctrl_bypass <= 1'b0;
      prescale    <= PRESCALE_W'(16'h00FF);
      tcnt        <= '0;
      pcnt        <= 4'd0;
      led_out     <= '0;
      for (int i = 0; i < CHANNELS; i++) level[i] <= 4'd0;
    end else begin
      if (wr_ctrl) begin
        ctrl_enable <= writedata[0];
        ctrl_bypass <= writedata[1];
      end
      if (wr_prescale) prescale <= writedata[PRESCALE_W-1:0];

      if (wr_prescale || tick) tcnt <= '0;
      else                     tcnt <= tcnt + 1'b1;

      pcnt <= (pcnt == 4'd14) ? 4'd0 : pcnt + 4'd1;

      // Step one unit toward the target, saturating at both ends.
      if (tick && ctrl_enable) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (in_port[i] && level[i] != 4'd15)       level[i] <= level[i] + 4'd1;
          else if (!in_port[i] && level[i] != 4'd0)  level[i] <= level[i] - 4'd1;
        end
      end

      led_out <= ctrl_bypass ? in_port : pwm;
    end
  end

endmodule
